// File: rtl/apu_pkg.sv
// apu_pkg: shared types and constants for the APU register sequencer
//   APU_NUM_REGS / APU_ADDR_W size the register file; apu_cmd_t is one queued command;
//   seq_state_t is the sequencer FSM state.
package apu_pkg;
  localparam int APU_NUM_REGS = 32;
  localparam int APU_ADDR_W = 5;
  typedef struct packed {
    logic wait_f;
    logic [APU_ADDR_W-1:0] addr;
    logic [7:0] data;
  } apu_cmd_t;
  typedef enum logic [1:0] {IDLE, DECODE, WAIT} seq_state_t;
endpackage

// File: rtl/apu_cmd_fifo.sv
// apu_cmd_fifo: DEPTH-entry command FIFO with head view, level and sync flush
//   clk/rst     clock, async active-high reset
//   flush       empties the FIFO on the next edge, blocks push/pop that cycle
//   push/push_cmd  write one command (ignored when full)
//   pop         advance the head (ignored when empty)
//   head        oldest entry; empty/full/level report occupancy
module apu_cmd_fifo
  import apu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  apu_cmd_t push_cmd,
  input  logic pop,
  output apu_cmd_t head,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  apu_cmd_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_cmd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/apu_reg_sequencer.sv
// apu_reg_sequencer: timed register-write scheduler feeding the APU register file
//   cmd_valid/cmd_ready/cmd_wait/cmd_addr/cmd_data  command port (write or quarter-frame wait)
//   flush         empties queue and aborts a wait; register contents kept
//   qfr_clk       quarter-frame clock, sampled through SYNC_STAGES flops
//   apu_reg_flat  32 x 8-bit registers, reg n at [8n+7:8n]
//   reg_wr_strobe one-hot, one-cycle pulse on each register write
//   busy / fifo_level  activity and queue occupancy
module apu_reg_sequencer
  import apu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_wait,
  input  logic [APU_ADDR_W-1:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic flush,
  input  logic qfr_clk,
  output logic [8*APU_NUM_REGS-1:0] apu_reg_flat,
  output logic [APU_NUM_REGS-1:0] reg_wr_strobe,
  output logic busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  apu_cmd_t head, cur;
  seq_state_t state;
  logic empty, full, push, pop, qfr_rise;
  logic [7:0] wait_cnt;
  logic [SYNC_STAGES-1:0] sync;
  assign cmd_ready = !full && !flush;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && !empty && !flush;
  assign busy = state != IDLE || !empty;
  // sync[0] is the newest sample; a rise is seen between the last two stages
  assign qfr_rise = sync[SYNC_STAGES-2] && !sync[SYNC_STAGES-1];
  apu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(push),
    .push_cmd({cmd_wait, cmd_addr, cmd_data}),
    .pop(pop),
    .head(head),
    .empty(empty),
    .full(full),
    .level(fifo_level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], qfr_clk};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= '0;
      wait_cnt <= '0;
      apu_reg_flat <= '0;
      reg_wr_strobe <= '0;
    end else begin
      reg_wr_strobe <= '0;
      // a write already in DECODE completes even when flush arrives that cycle
      if (state == DECODE && !cur.wait_f) begin
        apu_reg_flat[{cur.addr, 3'b000} +: 8] <= cur.data;
        reg_wr_strobe <= APU_NUM_REGS'(1) << cur.addr;
      end
      if (flush) begin
        state <= IDLE;
        wait_cnt <= '0;
      end else
        case (state)
          IDLE:
            if (!empty) begin
              cur <= head;
              state <= DECODE;
            end
          DECODE:
            if (cur.wait_f && cur.data != 8'd0) begin
              wait_cnt <= cur.data;
              state <= WAIT;
            end else state <= IDLE;
          WAIT:
            if (qfr_rise) begin
              wait_cnt <= wait_cnt - 8'd1;
              if (wait_cnt == 8'd1) state <= IDLE;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_apu_reg_sequencer.sv
// tb_apu_reg_sequencer: directed self-checking bench for apu_reg_sequencer
module tb_apu_reg_sequencer;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_wait = 0, flush = 0, qfr_clk = 0;
  logic cmd_ready, busy;
  logic [4:0] cmd_addr = 0;
  logic [7:0] cmd_data = 0;
  logic [255:0] apu_reg_flat, snap;
  logic [31:0] reg_wr_strobe;
  logic [3:0] fifo_level;
  int checks = 0, errors = 0;
  apu_reg_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wait(cmd_wait), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .flush(flush),
    .qfr_clk(qfr_clk), .apu_reg_flat(apu_reg_flat), .reg_wr_strobe(reg_wr_strobe),
    .busy(busy), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic w, input logic [4:0] a, input logic [7:0] d);
    cmd_valid = 1;
    cmd_wait = w;
    cmd_addr = a;
    cmd_data = d;
    step();
    cmd_valid = 0;
  endtask
  task automatic qpulse();
    qfr_clk = 1;
    step();
    step();
    qfr_clk = 0;
    step();
    step();
  endtask
  function automatic logic [7:0] rg(input int n);
    return apu_reg_flat[8*n +: 8];
  endfunction
  initial begin
    #12 rst = 0;
    step();
    chk("reset_regs", apu_reg_flat, 256'h0);
    chk("reset_strobe", reg_wr_strobe, 32'h0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_level", fifo_level, 4'd0);
    chk("reset_ready", cmd_ready, 1'b1);
    // single write: visible two edges after the push edge
    push(0, 5'd0, 8'h01);
    chk("w1_level", fifo_level, 4'd1);
    chk("w1_busy", busy, 1'b1);
    step();
    chk("w1_not_yet", rg(0), 8'h00);
    step();
    chk("w1_reg0", rg(0), 8'h01);
    chk("w1_strobe", reg_wr_strobe, 32'h1);
    step();
    chk("w1_strobe_off", reg_wr_strobe, 32'h0);
    chk("w1_busy_off", busy, 1'b0);
    // four writes, a wait 3, then a write that must follow the third quarter-frame rise
    push(0, 5'd0, 8'hBF);
    push(0, 5'd1, 8'h08);
    push(0, 5'd2, 8'hFD);
    push(0, 5'd3, 8'h00);
    push(1, 5'd0, 8'd3);
    push(0, 5'd3, 8'h01);
    step();
    chk("seq_reg0", rg(0), 8'hBF);
    chk("seq_reg1", rg(1), 8'h08);
    chk("seq_reg2", rg(2), 8'hFD);
    chk("seq_strobe2", reg_wr_strobe, 32'h4);
    step();
    chk("seq_gap", reg_wr_strobe, 32'h0);
    step();
    chk("seq_strobe3", reg_wr_strobe, 32'h8);
    chk("seq_reg3_zero", rg(3), 8'h00);
    step();
    step();
    step();
    qpulse();
    qpulse();
    step();
    step();
    chk("wait_hold_reg3", rg(3), 8'h00);
    chk("wait_hold_level", fifo_level, 4'd1);
    chk("wait_hold_busy", busy, 1'b1);
    qfr_clk = 1;
    step();
    step();
    step();
    chk("wait_pop_reg3", rg(3), 8'h00);
    step();
    chk("wait_done_reg3", rg(3), 8'h01);
    chk("wait_done_strobe", reg_wr_strobe, 32'h8);
    qfr_clk = 0;
    step();
    step();
    chk("wait_done_busy", busy, 1'b0);
    // fill the FIFO behind a long wait
    push(1, 5'd0, 8'd200);
    for (int i = 0; i < 8; i++) push(0, 5'(4 + i), 8'(8'h10 + i));
    chk("full_ready", cmd_ready, 1'b0);
    chk("full_level", fifo_level, 4'd8);
    for (int i = 0; i < 199; i++) qpulse();
    chk("full_hold_level", fifo_level, 4'd8);
    chk("full_hold_ready", cmd_ready, 1'b0);
    qfr_clk = 1;
    step();
    step();
    chk("full_exit_ready", cmd_ready, 1'b0);
    step();
    chk("full_pop_level", fifo_level, 4'd7);
    chk("full_pop_ready", cmd_ready, 1'b1);
    qfr_clk = 0;
    repeat (20) step();
    chk("full_drain_reg4", rg(4), 8'h10);
    chk("full_drain_reg11", rg(11), 8'h17);
    chk("full_drain_busy", busy, 1'b0);
    // flush during a wait with queued writes; a same-cycle push is dropped
    push(1, 5'd0, 8'd5);
    for (int i = 0; i < 4; i++) push(0, 5'(12 + i), 8'h55);
    chk("flush_pre_level", fifo_level, 4'd4);
    snap = apu_reg_flat;
    flush = 1;
    cmd_valid = 1;
    cmd_wait = 0;
    cmd_addr = 5'd16;
    cmd_data = 8'h77;
    #1;
    chk("flush_ready_low", cmd_ready, 1'b0);
    step();
    flush = 0;
    cmd_valid = 0;
    chk("flush_level", fifo_level, 4'd0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_regs", apu_reg_flat, snap);
    repeat (4) step();
    chk("flush_no_push", rg(16), 8'h00);
    chk("flush_regs_later", apu_reg_flat, snap);
    // async reset mid-cycle during a wait
    push(1, 5'd0, 8'd5);
    push(0, 5'd20, 8'h33);
    step();
    #2 rst = 1;
    #1;
    chk("arst_regs", apu_reg_flat, 256'h0);
    chk("arst_strobe", reg_wr_strobe, 32'h0);
    chk("arst_level", fifo_level, 4'd0);
    chk("arst_busy", busy, 1'b0);
    #3 rst = 0;
    step();
    chk("arst_ready", cmd_ready, 1'b1);
    // wait 0 is a no-op even with qfr_clk held low
    push(1, 5'd0, 8'd0);
    push(0, 5'd31, 8'hAA);
    step();
    step();
    chk("w0_not_yet", rg(31), 8'h00);
    step();
    chk("w0_reg31", rg(31), 8'hAA);
    chk("w0_strobe", reg_wr_strobe, 32'h8000_0000);
    step();
    chk("w0_strobe_off", reg_wr_strobe, 32'h0);
    chk("w0_busy", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
